// File: rtl/sdram_bus_sequencer.sv
// sdram_bus_sequencer: host burst front end that buffers write beats and sequences
// one request at a time into the SDRAM controller's Status/Write/Burst/Addr_32 port.
module sdram_bus_sequencer (
    input  logic        clock,
    input  logic        bar_reset,
    input  logic        HReq,
    input  logic        HWrite,
    input  logic [31:0] HAddr,
    input  logic [2:0]  HBurst,
    input  logic [31:0] HWData,
    input  logic        HWValid,
    output logic        HWTake,
    output logic [31:0] HRData,
    output logic        HRValid,
    output logic        HBusy,
    output logic        HDone,
    input  logic        Ready,
    input  logic        EnWData,
    input  logic        EnRData,
    input  logic [31:0] RData,
    output logic        Status,
    output logic        Write,
    output logic [2:0]  Burst,
    output logic [31:0] Addr_32,
    output logic [31:0] WData
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] WAITRDY = 3'd2;
    localparam logic [2:0] ISSUE   = 3'd3;
    localparam logic [2:0] DATA    = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic [31:0] buffer [8];
    logic [3:0]  wcnt;
    logic [3:0]  bcnt;
    logic [3:0]  beats;
    logic [3:0]  bcnt_inc;
    logic        beat;

    assign beats    = {1'b0, Burst} + 4'd1;
    assign bcnt_inc = bcnt + 4'd1;
    assign HWTake   = HWValid && state == LOAD && wcnt < beats;
    assign beat     = (state == ISSUE || state == DATA) && bcnt < beats && (Write ? EnWData : EnRData);
    assign Status   = state == ISSUE;
    assign HBusy    = state != IDLE;
    assign HDone    = state == DONE;

    always_ff @(posedge clock) begin
        if (HWTake)
            buffer[wcnt[2:0]] <= HWData;
    end

    always_ff @(posedge clock or negedge bar_reset) begin
        if (!bar_reset) begin
            state   <= IDLE;
            wcnt    <= 4'd0;
            bcnt    <= 4'd0;
            Write   <= 1'b0;
            Burst   <= 3'd0;
            Addr_32 <= 32'd0;
            WData   <= 32'd0;
            HRData  <= 32'd0;
            HRValid <= 1'b0;
        end else begin
            HRValid <= beat && !Write;
            if (beat && !Write)
                HRData <= RData;
            case (state)
                IDLE: if (HReq) begin
                    Write   <= HWrite;
                    Addr_32 <= HAddr;
                    Burst   <= HBurst;
                    wcnt    <= 4'd0;
                    bcnt    <= 4'd0;
                    state   <= HWrite ? LOAD : WAITRDY;
                end
                LOAD: if (HWTake) begin
                    wcnt  <= wcnt + 4'd1;
                    state <= (wcnt + 4'd1 == beats) ? WAITRDY : LOAD;
                end
                WAITRDY: if (Ready) begin
                    state <= ISSUE;
                    WData <= Write ? buffer[0] : 32'd0;
                end
                // a single-beat burst finishes straight from ISSUE so HDone follows the last beat
                ISSUE, DATA: if (beat) begin
                    bcnt  <= bcnt_inc;
                    state <= (bcnt_inc == beats) ? DONE : DATA;
                    if (Write)
                        WData <= (bcnt_inc == beats) ? 32'd0 : buffer[bcnt_inc[2:0]];
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_bus_sequencer.sv
// tb_sdram_bus_sequencer: table-driven vectors plus scoreboarded write/read bursts
// for the host-side SDRAM burst sequencer.
module tb_sdram_bus_sequencer;
    logic        clock = 1'b0;
    logic        bar_reset = 1'b1;
    logic        HReq, HWrite, HWValid, Ready, EnWData, EnRData;
    logic [31:0] HAddr, HWData, RData;
    logic [2:0]  HBurst;
    logic        HWTake, HRValid, HBusy, HDone, Status, Write;
    logic [31:0] HRData, Addr_32, WData;
    logic [2:0]  Burst;

    int          checks = 0;
    int          failures = 0;
    int          hrv_count = 0;
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic        rbeat = 1'b0;
    logic        exp_v = 1'b0;
    logic        mon_on = 1'b0;

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] hwdata;
        logic [31:0] addr;
        logic [3:0]  flg;
        logic [31:0] wdata;
    } vec_t;
    vec_t tv[15];

    sdram_bus_sequencer dut (
        .clock(clock), .bar_reset(bar_reset), .HReq(HReq), .HWrite(HWrite), .HAddr(HAddr),
        .HBurst(HBurst), .HWData(HWData), .HWValid(HWValid), .HWTake(HWTake), .HRData(HRData),
        .HRValid(HRValid), .HBusy(HBusy), .HDone(HDone), .Ready(Ready), .EnWData(EnWData),
        .EnRData(EnRData), .RData(RData), .Status(Status), .Write(Write), .Burst(Burst),
        .Addr_32(Addr_32), .WData(WData)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // read-data scoreboard: HRValid must follow an accepted EnRData by exactly one cycle
    always @(posedge clock or negedge bar_reset) exp_v <= bar_reset ? rbeat : 1'b0;

    always @(negedge clock) begin
        if (mon_on) begin
            chkb("hrvalid", HRValid, exp_v);
            if (HRValid) begin
                hrv_count++;
                if (rq.size() > 0)
                    chk("hrdata", HRData, rq.pop_front());
                else begin
                    checks++;
                    failures++;
                    $display("FAIL hrdata: unexpected beat %h", HRData);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle_in();
        HReq = 0; HWrite = 0; HAddr = 0; HBurst = 0; HWData = 0; HWValid = 0;
        Ready = 0; EnWData = 0; EnRData = 0; RData = 0; rbeat = 0;
    endtask

    task automatic chk_reset(input string tag);
        chkb({tag, "_status"}, Status, 1'b0);
        chkb({tag, "_write"}, Write, 1'b0);
        chk({tag, "_burst"}, 32'(Burst), 32'd0);
        chk({tag, "_addr"}, Addr_32, 32'd0);
        chk({tag, "_wdata"}, WData, 32'd0);
        chk({tag, "_hrdata"}, HRData, 32'd0);
        chkb({tag, "_hrvalid"}, HRValid, 1'b0);
        chkb({tag, "_hwtake"}, HWTake, 1'b0);
        chkb({tag, "_hbusy"}, HBusy, 1'b0);
        chkb({tag, "_hdone"}, HDone, 1'b0);
    endtask

    task automatic write8(input int rst_beat);
        idle_in(); HReq = 1; HWrite = 1; HAddr = 32'h3FF; HBurst = 3'd7;
        mid(); chkb("w8_idle_busy", HBusy, 1'b0); nxt();
        idle_in();
        for (int i = 0; i < 8; i++) begin
            HWValid = 1; HWData = 32'(i + 1); wq.push_back(HWData);
            mid(); chkb("w8_take", HWTake, 1'b1); chkb("w8_load_busy", HBusy, 1'b1); nxt();
        end
        HWValid = 0; Ready = 1;
        mid(); chkb("w8_wait_status", Status, 1'b0); chkb("w8_wait_take", HWTake, 1'b0); nxt();
        Ready = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == rst_beat) begin
                #1 bar_reset = 0;
                #1 chk_reset("async");
                wq.delete();
                nxt();
                bar_reset = 1;
                return;
            end
            EnWData = 1;
            mid();
            chk("w8_wdata", WData, wq.pop_front());
            chkb("w8_status", Status, i == 0);
            chk("w8_burst", 32'(Burst), 32'd7);
            chk("w8_addr", Addr_32, 32'h3FF);
            nxt();
        end
        EnWData = 0;
        mid(); chkb("w8_done", HDone, 1'b1); chk("w8_wdata_end", WData, 32'd0); nxt();
        mid(); chkb("w8_done_end", HDone, 1'b0); chkb("w8_busy_end", HBusy, 1'b0); nxt();
    endtask

    task automatic read_burst(input logic [2:0] hb, input int nen, input logic [31:0] base,
                              input logic stray, input logic busy_req);
        int start = hrv_count;
        idle_in(); HReq = 1; HWrite = 0; HAddr = base; HBurst = hb;
        mid(); nxt();
        idle_in(); Ready = 1;
        mid(); chkb("rd_wait_status", Status, 1'b0); chkb("rd_wait_busy", HBusy, 1'b1); nxt();
        Ready = 0;
        for (int i = 0; i < nen; i++) begin
            EnRData = 1; EnWData = stray; RData = 32'hA0 + 32'(i);
            rbeat = (i <= int'(hb));
            if (rbeat) rq.push_back(RData);
            HReq = busy_req && i == 2; HWrite = HReq; HAddr = HReq ? 32'hBAD : 32'd0;
            mid();
            chkb("rd_status", Status, i == 0);
            chkb("rd_done", HDone, i == int'(hb) + 1);
            chkb("rd_busy", HBusy, i <= int'(hb) + 1);
            chk("rd_addr", Addr_32, base);
            chkb("rd_write", Write, 1'b0);
            nxt();
        end
        idle_in();
        if (nen == int'(hb) + 1) begin
            mid(); chkb("rd_done_pulse", HDone, 1'b1); nxt();
        end
        for (int i = 0; i < 2; i++) begin
            mid(); chkb("rd_idle_done", HDone, 1'b0); chkb("rd_idle_busy", HBusy, 1'b0); nxt();
        end
        chk("rd_beats", 32'(hrv_count - start), 32'(hb) + 32'd1);
        chk("rd_drained", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        tv[0]  = '{5'b11000, 32'h0,        32'h55,  4'b0000, 32'h0};
        tv[1]  = '{5'b00000, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[2]  = '{5'b00000, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[3]  = '{5'b00000, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[4]  = '{5'b00100, 32'hDEADBEEF, 32'h0,   4'b1100, 32'h0};
        tv[5]  = '{5'b00100, 32'h1234,     32'h0,   4'b1000, 32'h0};
        tv[6]  = '{5'b10000, 32'h0,        32'hBAD, 4'b1000, 32'h0};
        tv[7]  = '{5'b00000, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[8]  = '{5'b00000, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[9]  = '{5'b00000, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[10] = '{5'b00010, 32'h0,        32'h0,   4'b1000, 32'h0};
        tv[11] = '{5'b00000, 32'h0,        32'h0,   4'b1010, 32'hDEADBEEF};
        tv[12] = '{5'b00001, 32'h0,        32'h0,   4'b1010, 32'hDEADBEEF};
        tv[13] = '{5'b00001, 32'h0,        32'h0,   4'b1001, 32'h0};
        tv[14] = '{5'b00000, 32'h0,        32'h0,   4'b0000, 32'h0};

        idle_in();
        #1 bar_reset = 0;
        #1 chk_reset("reset");
        nxt(); nxt();
        bar_reset = 1;
        mon_on = 1;

        for (int i = 0; i < 15; i++) begin
            {HReq, HWrite, HWValid, Ready, EnWData} = tv[i].ctl;
            HWData = tv[i].hwdata; HAddr = tv[i].addr;
            mid();
            chkb($sformatf("t%0d_busy", i), HBusy, tv[i].flg[3]);
            chkb($sformatf("t%0d_take", i), HWTake, tv[i].flg[2]);
            chkb($sformatf("t%0d_status", i), Status, tv[i].flg[1]);
            chkb($sformatf("t%0d_done", i), HDone, tv[i].flg[0]);
            chk($sformatf("t%0d_wdata", i), WData, tv[i].wdata);
            nxt();
        end
        idle_in();
        chk("t_addr", Addr_32, 32'h55);
        chk("t_burst", 32'(Burst), 32'd0);
        chkb("t_write", Write, 1'b1);

        write8(8);
        read_burst(3'd3, 4, 32'h100, 1'b0, 1'b1);
        read_burst(3'd1, 4, 32'h200, 1'b1, 1'b0);
        write8(3);
        read_burst(3'd2, 3, 32'h300, 1'b0, 1'b0);
        write8(8);

        mon_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
